// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared types and constants for the Basys3 stopwatch: run-control state
//   encoding, default debounce length, and the run-control next-state rule.
//   The button front end and the stopwatch counter both import this.
package stopwatch_pkg;

  // 10 ms at 100 MHz
  localparam int DB_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // Reset press dominates and discards a same-cycle start/stop press.
  // The spare encoding 2'd3 falls back to IDLE on the next clock.
  function automatic sw_state_t sw_next(sw_state_t s, logic rst_p, logic ss_p);
    sw_state_t n;
    if (rst_p) begin
      n = IDLE;
    end else begin
      case (s)
        IDLE:    n = ss_p ? RUN   : IDLE;
        RUN:     n = ss_p ? PAUSE : RUN;
        PAUSE:   n = ss_p ? RUN   : PAUSE;
        default: n = IDLE;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_buttons_debounce.sv
// debounce
//   One pushbutton conditioning chain: 2-flop synchronizer, counter-based
//   debouncer and rising-edge detector.
//   Ports:
//     clk    in   system clock
//     reset  in   async active-high reset, clears every flop
//     btn    in   raw asynchronous, bouncy button
//     level  out  debounced button level
//     press  out  registered one-cycle pulse on each accepted press
module debounce
  import stopwatch_pkg::*;
#(
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int DB_W      = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  logic [1:0]      r_sync;
  logic            r_level;
  logic            r_level_q;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;
  logic            w_sync;

  assign w_sync = r_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync    <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn};
      // Any cycle agreeing with the current level restarts the count, so
      // only DB_CYCLES consecutive differing samples can flip the level.
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_W'(DB_CYCLES - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/stopwatch_buttons.sv
// stopwatch_buttons
//   Button front end for the stopwatch: conditions the start/stop and reset
//   pushbuttons and runs the IDLE/RUN/PAUSE run-control FSM.
//   Ports:
//     clk         in   100 MHz system clock
//     reset       in   async active-high reset
//     btn_ss      in   raw start/stop button
//     btn_rst     in   raw reset button
//     start_stop  out  counter enable, high only in RUN
//     clear       out  one-cycle counter clear pulse per reset press
//     state       out  FSM state (LEDs / debug)
module stopwatch_buttons
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_rst,
  output logic       start_stop,
  output logic       clear,
  output logic [1:0] state
);

  logic      w_ss_press;
  logic      w_rst_press;
  logic      w_ss_level;
  logic      w_rst_level;
  sw_state_t w_next;

  sw_state_t r_state;
  logic      r_start_stop;
  logic      r_clear;

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .level (w_ss_level),
    .press (w_ss_press)
  );

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_rst),
    .level (w_rst_level),
    .press (w_rst_press)
  );

  // Debounced levels are debug taps only; the FSM acts on presses.
  logic w_unused;
  assign w_unused = &{1'b0, w_ss_level, w_rst_level};

  assign w_next = sw_next(r_state, w_rst_press, w_ss_press);

  // Outputs are registered off the next state so they change together
  // with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_start_stop <= 1'b0;
      r_clear      <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_start_stop <= (w_next == RUN);
      r_clear      <= w_rst_press;
    end
  end

  assign start_stop = r_start_stop;
  assign clear      = r_clear;
  assign state      = r_state;

endmodule

// File: tb/tb_stopwatch_buttons.sv
module tb_stopwatch_buttons;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0;
  logic       btn_rst = 1'b0;
  logic       start_stop;
  logic       clear;
  logic [1:0] state;

  stopwatch_buttons #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_ss     (btn_ss),
    .btn_rst    (btn_rst),
    .start_stop (start_stop),
    .clear      (clear),
    .state      (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt = 0;
  int trans_cnt = 0;
  logic [1:0] prev_state = 2'd0;

  typedef struct {
    logic ss;
    logic rst;
    int   cyc;
    int   st;
    int   so;
    int   clrs;
    int   trans;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (clear) clr_cnt++;
    if (state != prev_state) trans_cnt++;
    prev_state = state;
  endtask

  task automatic hold(input logic ss, input logic rst, input int n);
    btn_ss  = ss;
    btn_rst = rst;
    repeat (n) tick();
  endtask

  task automatic add(input logic ss, input logic rst, input int cyc,
                     input int st, input int so, input int clrs, input int tr);
    vec_t v;
    v.ss = ss; v.rst = rst; v.cyc = cyc;
    v.st = st; v.so = so; v.clrs = clrs; v.trans = tr;
    vecs.push_back(v);
  endtask

  int bnc[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};

  initial begin
    // {ss, rst, cycles, state, start_stop, clear pulses, state changes}
    add(1, 0, 12, 1, 1, 0, 1);   // IDLE -> RUN
    add(0, 0, 12, 1, 1, 0, 0);   // release: nothing
    add(1, 0, 12, 2, 0, 0, 1);   // RUN -> PAUSE
    add(0, 0, 12, 2, 0, 0, 0);
    add(1, 0, 12, 1, 1, 0, 1);   // PAUSE -> RUN
    add(0, 0, 12, 1, 1, 0, 0);
    add(0, 1, 12, 0, 0, 1, 1);   // reset in RUN
    add(0, 0, 12, 0, 0, 0, 0);
    add(0, 1, 12, 0, 0, 1, 0);   // reset again in IDLE still clears
    add(0, 0, 12, 0, 0, 0, 0);
    add(1, 0,  3, 0, 0, 0, 0);   // 3-cycle glitch
    add(0, 0, 12, 0, 0, 0, 0);
    add(1, 0, 12, 1, 1, 0, 1);
    add(0, 0, 12, 1, 1, 0, 0);
    add(1, 0, 12, 2, 0, 0, 1);   // into PAUSE
    add(0, 0, 12, 2, 0, 0, 0);
    add(1, 1, 12, 0, 0, 1, 1);   // simultaneous from PAUSE: reset wins
    add(0, 0, 12, 0, 0, 0, 0);
    add(1, 0, 100, 1, 1, 0, 1);  // long hold: one transition
    add(0, 0, 12, 1, 1, 0, 0);

    // Reset held with a running clock
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_stop", int'(start_stop), 0);
    chk("rst_clear", int'(clear), 0);
    chk("rst_state", int'(state), 0);
    reset = 1'b0;
    prev_state = state;

    // Clean press: edge 0 is the edge just before the button goes high
    btn_ss = 1'b1;
    repeat (7) tick();
    chk("press_edge7_start_stop", int'(start_stop), 0);
    chk("press_edge7_state", int'(state), 0);
    tick();
    chk("press_edge8_start_stop", int'(start_stop), 1);
    chk("press_edge8_state", int'(state), 1);
    hold(0, 0, 12);
    hold(0, 1, 12);
    hold(0, 0, 12);
    chk("back_to_idle", int'(state), 0);

    // Bounce: final stable run starts at pattern index 5
    clr_cnt = 0; trans_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_ss = bnc[i][0];
      tick();
    end
    tick(); tick();   // 7 edges since the final run began
    chk("bounce_edge7_start_stop", int'(start_stop), 0);
    tick();
    chk("bounce_edge8_start_stop", int'(start_stop), 1);
    hold(1, 0, 20);
    chk("bounce_transitions", trans_cnt, 1);
    chk("bounce_state", int'(state), 1);
    hold(0, 0, 12);
    hold(0, 1, 12);
    hold(0, 0, 12);

    // Table-driven vectors with scoreboard
    foreach (vecs[i]) begin
      vec_t e;
      sb.push_back(vecs[i]);
      clr_cnt = 0; trans_cnt = 0;
      hold(vecs[i].ss, vecs[i].rst, vecs[i].cyc);
      e = sb.pop_front();
      chk($sformatf("vec%0d_state", i), int'(state), e.st);
      chk($sformatf("vec%0d_start_stop", i), int'(start_stop), e.so);
      chk($sformatf("vec%0d_clear_pulses", i), clr_cnt, e.clrs);
      chk($sformatf("vec%0d_transitions", i), trans_cnt, e.trans);
    end

    // Start/stop press landing in the cycle clear is high (from RUN)
    clr_cnt = 0;
    btn_rst = 1'b1;
    tick();
    btn_ss = 1'b1;
    repeat (6) tick();
    chk("clrss_edge7_state", int'(state), 1);
    tick();
    chk("clrss_edge8_clear", int'(clear), 1);
    chk("clrss_edge8_state", int'(state), 0);
    tick();
    chk("clrss_edge9_clear", int'(clear), 0);
    chk("clrss_edge9_state", int'(state), 1);
    chk("clrss_edge9_start_stop", int'(start_stop), 1);
    hold(1, 1, 10);
    chk("clrss_clear_pulses", clr_cnt, 1);
    hold(0, 0, 12);

    // Reset mid-debounce with the button held (state is RUN here)
    btn_ss = 1'b1;
    repeat (4) tick();   // debounce counter at 2
    #2 reset = 1'b1;
    #1;
    chk("middb_async_state", int'(state), 0);
    chk("middb_async_start_stop", int'(start_stop), 0);
    chk("middb_async_clear", int'(clear), 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (7) tick();
    chk("middb_edge7_state", int'(state), 0);
    tick();
    chk("middb_edge8_state", int'(state), 1);
    chk("middb_edge8_start_stop", int'(start_stop), 1);

    // Async reset with buttons low, checked before any clock edge
    hold(0, 0, 12);
    chk("pre_async_start_stop", int'(start_stop), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_start_stop", int'(start_stop), 0);
    chk("async_clear", int'(clear), 0);
    chk("async_state", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
